// File: rtl/tx_link_pkg.sv
// Shared definitions for the TX link scheduler: 8B/10B control characters,
// FSM state encoding and the encoder character payload.
package tx_link_pkg;

  // Control characters presented to the encoder with kin=1
  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K28_0 = 8'h1C;  // stall filler inside a frame

  // Scheduler state enumeration
  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;
  localparam logic [2:0] ST_ALIGN = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SOF   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_EOF   = 3'd4;

  // One character towards the encoder (kin + datain)
  typedef struct packed {
    logic       kin;
    logic [7:0] data;
  } enc_char_t;

  // Build a control character
  function automatic enc_char_t kchar(input logic [7:0] code);
    enc_char_t c;
    c.kin  = 1'b1;
    c.data = code;
    return c;
  endfunction

  // Build a data character
  function automatic enc_char_t dchar(input logic [7:0] byte_in);
    enc_char_t c;
    c.kin  = 1'b0;
    c.data = byte_in;
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is a combinational decision; the
// priority pointer only moves when the owner strobes a frame-boundary grant.
// Ports:
//   clk, rst_n  clock, async active-low reset (s0 holds priority after reset)
//   i_req       request per source {s1, s0}
//   i_strobe    grant is being taken at a frame boundary
//   o_any_c     at least one request present
//   o_gnt_c     index of the winning source (valid when o_any_c)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_strobe,
  output logic       o_any_c,
  output logic       o_gnt_c
);

  // Source that wins a simultaneous request (the one not granted last)
  logic r_prio;

  // Priority holder wins if requesting, otherwise the other source
  always_comb begin
    o_any_c = |i_req;
    o_gnt_c = r_prio;
    if (!i_req[r_prio]) begin
      o_gnt_c = ~r_prio;
    end
  end

  // Hand priority to the source that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_strobe && o_any_c) begin
      r_prio <= ~o_gnt_c;
    end
  end

endmodule

// File: rtl/tx_link_sched.sv
// TX link scheduler: emits one 8B/10B character per clock. Runs a comma
// alignment burst, then frames bytes from two sources (round-robin at frame
// boundaries) as SOF / data / EOF, filling stalls with K28.0 and cutting
// frames at MAX_LEN bytes.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   realign                    request to re-run alignment (held pending)
//   sN_valid/sN_data/sN_last   source byte streams, sN_ready accepts
//   enc_data, enc_kin          registered character to the encoder
//   link_up                    high outside ALIGN
//   trunc                      one-cycle pulse with the byte that hit MAX_LEN
module tx_link_sched
  import tx_link_pkg::*;
#(
  parameter int unsigned ALIGN_LEN = 16,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       realign,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s0_ready,
  output logic       s1_ready,
  output logic [7:0] enc_data,
  output logic       enc_kin,
  output logic       link_up,
  output logic       trunc
);

  localparam int unsigned ACNT_W = $clog2(ALIGN_LEN + 1);
  localparam int unsigned BCNT_W = $clog2(MAX_LEN + 1);

  state_t            r_state, w_state_nxt;
  logic [ACNT_W-1:0] r_acnt, w_acnt_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic              r_gnt, w_gnt_nxt;
  logic              r_pend, w_pend_nxt;
  enc_char_t         r_char, w_char_nxt;
  logic              r_trunc, w_trunc_nxt;
  logic              r_link, w_link_nxt;
  logic [1:0]        r_rdy, w_rdy_nxt;
  logic              w_arb_strobe;
  logic              w_arb_any;
  logic              w_arb_gnt;
  logic              w_valid, w_last, w_acc;
  logic [7:0]        w_data;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({s1_valid, s0_valid}),
    .i_strobe (w_arb_strobe),
    .o_any_c  (w_arb_any),
    .o_gnt_c  (w_arb_gnt)
  );

  // Granted source stream; a byte is taken whenever that source is ready
  always_comb begin
    w_valid = r_gnt ? s1_valid : s0_valid;
    w_data  = r_gnt ? s1_data  : s0_data;
    w_last  = r_gnt ? s1_last  : s0_last;
    w_acc   = (r_state == ST_DATA) && w_valid;
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_acnt_nxt   = '0;
    w_bcnt_nxt   = r_bcnt;
    w_bcnt_inc   = r_bcnt + BCNT_W'(1);
    w_gnt_nxt    = r_gnt;
    w_pend_nxt   = r_pend | realign;
    w_char_nxt   = kchar(K28_5);
    w_trunc_nxt  = 1'b0;
    w_arb_strobe = 1'b0;

    case (r_state)
      ST_ALIGN: begin
        w_acnt_nxt = r_acnt + ACNT_W'(1);
        if (r_acnt == ACNT_W'(ALIGN_LEN - 1)) begin
          w_acnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A pending realign beats any waiting frame
        if (r_pend || realign) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_ALIGN;
        end else if (w_arb_any) begin
          w_gnt_nxt    = w_arb_gnt;
          w_arb_strobe = 1'b1;
          w_state_nxt  = ST_SOF;
        end
      end
      ST_SOF: begin
        w_char_nxt  = kchar(K27_7);
        w_bcnt_nxt  = '0;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_acc) begin
          w_char_nxt = dchar(w_data);
          w_bcnt_nxt = w_bcnt_inc;
          if (w_last) begin
            w_state_nxt = ST_EOF;
          end else if (w_bcnt_inc == BCNT_W'(MAX_LEN)) begin
            // Frame cut; the rest of this source's bytes form a later frame
            w_trunc_nxt = 1'b1;
            w_state_nxt = ST_EOF;
          end
        end else begin
          w_char_nxt = kchar(K28_0);
        end
      end
      ST_EOF: begin
        w_char_nxt  = kchar(K29_7);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_ALIGN;
      end
    endcase

    // Ready/link track the state being entered so they stay state-aligned
    w_rdy_nxt[0] = (w_state_nxt == ST_DATA) && !w_gnt_nxt;
    w_rdy_nxt[1] = (w_state_nxt == ST_DATA) &&  w_gnt_nxt;
    w_link_nxt   = (w_state_nxt != ST_ALIGN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ALIGN;
      r_acnt      <= '0;
      r_bcnt      <= '0;
      r_gnt       <= 1'b0;
      r_pend      <= 1'b0;
      r_char.kin  <= 1'b1;
      r_char.data <= K28_5;
      r_trunc     <= 1'b0;
      r_link      <= 1'b0;
      r_rdy       <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_acnt  <= w_acnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_pend  <= w_pend_nxt;
      r_char  <= w_char_nxt;
      r_trunc <= w_trunc_nxt;
      r_link  <= w_link_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  assign enc_data = r_char.data;
  assign enc_kin  = r_char.kin;
  assign trunc    = r_trunc;
  assign link_up  = r_link;
  assign s0_ready = r_rdy[0];
  assign s1_ready = r_rdy[1];

endmodule

// File: tb/tb_tx_link_sched.sv
// Bench for tx_link_sched: directed per-cycle vector table, alignment and
// reset sequences, then randomized two-source traffic checked against a
// frame-level reference model.
module tb_tx_link_sched;
  import tx_link_pkg::*;

  localparam int unsigned ALIGN_LEN = 16;
  localparam int unsigned MAX_LEN   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       realign = 1'b0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] enc_data;
  logic       enc_kin, link_up, trunc;

  int total = 0;
  int bad   = 0;

  tx_link_sched #(.ALIGN_LEN(ALIGN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .realign(realign),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .enc_data(enc_data), .enc_kin(enc_kin), .link_up(link_up), .trunc(trunc)
  );

  always #5 clk = ~clk;

  // Source fields are {valid, last, data}; expected char is {kin, data}
  typedef struct {
    logic [9:0] s0;
    logic [9:0] s1;
    logic       ra;
    logic [8:0] ech;
    logic [1:0] rdy;
    logic       tr;
    logic       lk;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] a, input logic [9:0] b, input logic ra,
                     input logic [8:0] ech, input logic [1:0] rdy, input logic tr,
                     input logic lk);
    vec_t v;
    v.s0 = a; v.s1 = b; v.ra = ra; v.ech = ech; v.rdy = rdy; v.tr = tr; v.lk = lk;
    vecs.push_back(v);
  endtask

  // Count edges until link_up, checking comma output throughout
  task automatic wait_link_up(input string tag);
    int n;
    n = 0;
    while (!link_up && n < 200) begin
      @(posedge clk); #1;
      n++;
      check({tag, "_align_char"}, {23'h0, enc_kin, enc_data}, 32'h1BC);
    end
    check({tag, "_align_len"}, n, ALIGN_LEN);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_char"}, {23'h0, enc_kin, enc_data}, 32'h1BC);
    check({tag, "_link"}, {31'h0, link_up}, 32'h0);
    check({tag, "_trunc"}, {31'h0, trunc}, 32'h0);
    check({tag, "_ready"}, {30'h0, s1_ready, s0_ready}, 32'h0);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s0_valid = 1'b0; s1_valid = 1'b0; realign = 1'b0;
      @(posedge clk); #1;
      check({tag, "_idle_char"}, {23'h0, enc_kin, enc_data}, 32'h1BC);
      check({tag, "_idle_link"}, {31'h0, link_up}, 32'h1);
    end
  endtask

  // Random-traffic state
  logic [8:0] srcq [2][$];
  logic [8:0] mq   [2][$];
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  int         exp_tr[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values and alignment ----------------
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_link_up("init");
    idle_cycles("init", 3);

    // ---------------- directed vector table ----------------
    // 3-byte frame from s0
    add(10'h211, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h211, 10'h000, 1'b0, 9'h1FB, 2'b01, 1'b0, 1'b1);
    add(10'h211, 10'h000, 1'b0, 9'h011, 2'b01, 1'b0, 1'b1);
    add(10'h222, 10'h000, 1'b0, 9'h022, 2'b01, 1'b0, 1'b1);
    add(10'h333, 10'h000, 1'b0, 9'h033, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    // s0 stalls two cycles mid-frame
    add(10'h2AA, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h2AA, 10'h000, 1'b0, 9'h1FB, 2'b01, 1'b0, 1'b1);
    add(10'h2AA, 10'h000, 1'b0, 9'h0AA, 2'b01, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h11C, 2'b01, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h11C, 2'b01, 1'b0, 1'b1);
    add(10'h2BB, 10'h000, 1'b0, 9'h0BB, 2'b01, 1'b0, 1'b1);
    add(10'h3CC, 10'h000, 1'b0, 9'h0CC, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    // s1 sends 6 bytes, cut after 4 with trunc, remainder in a new frame
    add(10'h000, 10'h201, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h201, 1'b0, 9'h1FB, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h201, 1'b0, 9'h001, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h202, 1'b0, 9'h002, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h203, 1'b0, 9'h003, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h204, 1'b0, 9'h004, 2'b00, 1'b1, 1'b1);
    add(10'h000, 10'h205, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h205, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h205, 1'b0, 9'h1FB, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h205, 1'b0, 9'h005, 2'b10, 1'b0, 1'b1);
    add(10'h000, 10'h306, 1'b0, 9'h006, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    // both sources busy: frames alternate s0, s1, s0
    add(10'h2A0, 10'h2B0, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h2A0, 10'h2B0, 1'b0, 9'h1FB, 2'b01, 1'b0, 1'b1);
    add(10'h2A0, 10'h2B0, 1'b0, 9'h0A0, 2'b01, 1'b0, 1'b1);
    add(10'h3A1, 10'h2B0, 1'b0, 9'h0A1, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B0, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B0, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B0, 1'b0, 9'h1FB, 2'b10, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B0, 1'b0, 9'h0B0, 2'b10, 1'b0, 1'b1);
    add(10'h2A2, 10'h3B1, 1'b0, 9'h0B1, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B2, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B2, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B2, 1'b0, 9'h1FB, 2'b01, 1'b0, 1'b1);
    add(10'h2A2, 10'h2B2, 1'b0, 9'h0A2, 2'b01, 1'b0, 1'b1);
    add(10'h3A3, 10'h2B2, 1'b0, 9'h0A3, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    // realign during SOF: frame completes, then ALIGN entered from IDLE
    add(10'h2C1, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b1);
    add(10'h2C1, 10'h000, 1'b1, 9'h1FB, 2'b01, 1'b0, 1'b1);
    add(10'h2C1, 10'h000, 1'b0, 9'h0C1, 2'b01, 1'b0, 1'b1);
    add(10'h2C2, 10'h000, 1'b0, 9'h0C2, 2'b01, 1'b0, 1'b1);
    add(10'h3C3, 10'h000, 1'b0, 9'h0C3, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1FD, 2'b00, 1'b0, 1'b1);
    add(10'h000, 10'h000, 1'b0, 9'h1BC, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      s0_valid = vecs[i].s0[9]; s0_last = vecs[i].s0[8]; s0_data = vecs[i].s0[7:0];
      s1_valid = vecs[i].s1[9]; s1_last = vecs[i].s1[8]; s1_data = vecs[i].s1[7:0];
      realign  = vecs[i].ra;
      @(posedge clk); #1;
      check($sformatf("vec%0d_char", i), {23'h0, enc_kin, enc_data}, {23'h0, vecs[i].ech});
      check($sformatf("vec%0d_ready", i), {30'h0, s1_ready, s0_ready}, {30'h0, vecs[i].rdy});
      check($sformatf("vec%0d_trunc", i), {31'h0, trunc}, {31'h0, vecs[i].tr});
      check($sformatf("vec%0d_link", i), {31'h0, link_up}, {31'h0, vecs[i].lk});
    end
    wait_link_up("realign");
    idle_cycles("realign", 2);

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s1_valid = 1'b1; s1_data = 8'hE1; s1_last = 1'b0;
      @(posedge clk); #1;
    end
    check("midframe_ready", {30'h0, s1_ready, s0_ready}, 32'h2);
    check("midframe_char", {23'h0, enc_kin, enc_data}, 32'h0E1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    s1_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    wait_link_up("midrst");
    idle_cycles("midrst", 2);

    // ---------------- randomized traffic vs frame model ----------------
    begin
      int         nframes, frames_done, cyc, exp_stalls, stalls_seen;
      int         fr_len, fr_tr, prio, s, n, len;
      logic       in_frame, idle_seen, done, lst;
      logic [8:0] w;
      for (int src = 0; src < 2; src++) begin
        for (int f = 0; f < 12; f++) begin
          len = int'($urandom_range(1, 7));
          for (int b = 0; b < len; b++) begin
            lst = (b == len - 1);
            w = {lst, 1'(src), 7'($urandom)};
            srcq[src].push_back(w);
          end
        end
      end
      // Reference: split each grant at last or MAX_LEN, alternate on contention
      mq[0] = srcq[0];
      mq[1] = srcq[1];
      prio = 0;
      while (mq[0].size() > 0 || mq[1].size() > 0) begin
        if (mq[0].size() > 0 && mq[1].size() > 0) s = prio;
        else s = (mq[0].size() > 0) ? 0 : 1;
        prio = 1 - s;
        n = 0; done = 1'b0; fr_tr = 0;
        while (!done) begin
          w = mq[s].pop_front();
          exp_bytes.push_back(w[7:0]);
          n++;
          if (w[8]) done = 1'b1;
          else if (n == int'(MAX_LEN)) begin done = 1'b1; fr_tr = 1; end
        end
        exp_len.push_back(n);
        exp_tr.push_back(fr_tr);
      end
      nframes = exp_len.size();

      frames_done = 0; cyc = 0; exp_stalls = 0; stalls_seen = 0;
      in_frame = 1'b0; idle_seen = 1'b1; fr_len = 0; fr_tr = 0;
      while (frames_done < nframes && cyc < 20000) begin
        @(negedge clk);
        for (int src = 0; src < 2; src++) begin
          logic       r, v;
          logic [8:0] h;
          r = (src == 0) ? s0_ready : s1_ready;
          v = (srcq[src].size() > 0) && (!r || ($urandom_range(0, 3) != 0));
          h = (srcq[src].size() > 0) ? srcq[src][0] : 9'h0;
          if (src == 0) begin s0_valid = v; s0_data = h[7:0]; s0_last = h[8]; end
          else          begin s1_valid = v; s1_data = h[7:0]; s1_last = h[8]; end
          if (r && v) h = srcq[src].pop_front();
          if (r && !v) exp_stalls++;
        end
        @(posedge clk); #1;
        cyc++;
        check("rand_ready_excl", {31'h0, s0_ready & s1_ready}, 32'h0);
        check("rand_link", {31'h0, link_up}, 32'h1);
        if (enc_kin) begin
          case (enc_data)
            K28_5: begin
              check("rand_idle_outside", {31'h0, in_frame}, 32'h0);
              idle_seen = 1'b1;
            end
            K27_7: begin
              check("rand_sof_outside", {31'h0, in_frame}, 32'h0);
              check("rand_idle_before_sof", {31'h0, idle_seen}, 32'h1);
              in_frame = 1'b1; fr_len = 0; fr_tr = 0;
            end
            K28_0: begin
              check("rand_stall_in_frame", {31'h0, in_frame}, 32'h1);
              stalls_seen++;
            end
            K29_7: begin
              check("rand_eof_in_frame", {31'h0, in_frame}, 32'h1);
              check("rand_frame_avail", {31'h0, exp_len.size() > 0}, 32'h1);
              if (exp_len.size() > 0) begin
                n = exp_len.pop_front();
                check($sformatf("rand_frame%0d_len", frames_done), fr_len, n);
                n = exp_tr.pop_front();
                check($sformatf("rand_frame%0d_trunc", frames_done), fr_tr, n);
              end
              in_frame = 1'b0; idle_seen = 1'b0;
              frames_done++;
            end
            default: check("rand_kcode", {24'h0, enc_data}, 32'hBC);
          endcase
        end else begin
          check("rand_data_in_frame", {31'h0, in_frame}, 32'h1);
          check("rand_byte_avail", {31'h0, exp_bytes.size() > 0}, 32'h1);
          fr_len++;
          if (exp_bytes.size() > 0) begin
            w = {1'b0, exp_bytes.pop_front()};
            check("rand_byte", {24'h0, enc_data}, {24'h0, w[7:0]});
          end
        end
        if (trunc) begin
          check("rand_trunc_in_frame", {31'h0, in_frame}, 32'h1);
          fr_tr++;
        end
      end
      check("rand_frames", frames_done, nframes);
      check("rand_bytes_left", exp_bytes.size(), 0);
      check("rand_stalls", stalls_seen, exp_stalls);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_link_sched.md
TX_LINK_SCHED -- requirements
Module: tx_link_sched

Interface
REQ-001 Parameter ALIGN_LEN, default 16: number of K28.5 comma characters sent in the ALIGN state.
REQ-002 Parameter MAX_LEN, default 256: maximum data bytes per frame; range 1..1024.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 realign  input  1  request to re-enter ALIGN; sampled each cycle and held pending until serviced.
REQ-006 s0_valid, s1_valid  input  1 each  source byte valid.
REQ-007 s0_data, s1_data  input  8 each  source byte.
REQ-008 s0_last, s1_last  input  1 each  marks the final byte of a frame.
REQ-009 s0_ready, s1_ready  output  1 each  byte accepted when valid and ready are both high.
REQ-010 enc_data  output  8  byte to the 8B/10B encoder datain.
REQ-011 enc_kin  output  1  control-character flag to the encoder kin.
REQ-012 link_up  output  1  high once ALIGN completes; low during ALIGN.
REQ-013 trunc  output  1  one-cycle pulse when a frame is cut at MAX_LEN.

Function
REQ-014 Exactly one character SHALL be emitted every clock; enc_data/enc_kin registered, one cycle after the state/beat that selects them.
REQ-015 Character codes: K28.5 = 0xBC (comma/idle), K27.7 = 0xFB (SOF), K29.7 = 0xFD (EOF), K28.0 = 0x1C (stall filler); all with enc_kin=1; data bytes with enc_kin=0.
REQ-016 States: ALIGN, IDLE, SOF, DATA, EOF.
REQ-017 ALIGN: emit K28.5 for ALIGN_LEN cycles (counter), then go to IDLE and set link_up.
REQ-018 IDLE: emit K28.5; if realign pending go to ALIGN (clear pending, drop link_up); else if any sN_valid, latch grant and go to SOF.
REQ-019 Grant: round-robin between s0/s1 at frame boundaries only; on simultaneous requests the source not granted last wins; after reset s0 has priority.
REQ-020 SOF: emit K27.7 for one cycle, then DATA.
REQ-021 DATA: ready of the granted source = 1, other ready = 0; accepted byte emitted as data; granted valid low emits K28.0.
REQ-022 Accepted byte with last=1 SHALL move to EOF.
REQ-023 Byte count reaching MAX_LEN without last SHALL move to EOF and pulse trunc; the source's remaining bytes start a new frame later.
REQ-024 EOF: emit K29.7 for one cycle, then IDLE (at least one K28.5 between frames).
REQ-025 realign arriving during SOF/DATA/EOF SHALL be deferred until IDLE; the frame is never cut.
REQ-026 sN_ready SHALL be 0 outside DATA and while rst_n is low.

Reset
REQ-027 rst_n low SHALL immediately force state ALIGN, counters 0, grant pointer to s0, realign pending 0.
REQ-028 Reset values: enc_data=0xBC, enc_kin=1, link_up=0, trunc=0, s0_ready=s1_ready=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no EOF; after release ALIGN restarts from count 0.

Structure
REQ-030 Shared package tx_link_pkg SHALL hold the K-character constants and the state enumeration.
REQ-031 Round-robin arbitration SHALL be a sub-module rr_arb2 (2 requests, grant-at-boundary strobe, last-grant register).

Verification
REQ-032 Release reset, ALIGN_LEN=16 -> 16 cycles of 0xBC/k=1, link_up rises, then continuous 0xBC idle.
REQ-033 s0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) -> 0xFB k, 0x11,0x22,0x33 k=0, 0xFD k, 0xBC k.
REQ-034 s0 and s1 both valid continuously with 2-byte frames -> frames alternate s0,s1,s0, each separated by EOF then ≥1 idle.
REQ-035 s0 drops valid for 2 cycles mid-frame -> two 0x1C k=1 characters inserted, no byte lost or duplicated.
REQ-036 MAX_LEN=4, s1 sends 6 bytes with no last until byte 6 -> 4 bytes, EOF, trunc pulse, idle, new SOF carrying bytes 5-6.
REQ-037 realign pulsed mid-frame, then rst_n pulsed mid-frame on a second frame -> first frame completes before ALIGN; second abandoned, outputs at reset values at once.
